// File: rtl/sweep_pkg.sv
// Shared types and default widths for the frequency-sweep sequencer.
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEAS,
      ST_OUT
   } state_t;

   localparam int DEF_FWORD_WIDTH = 32;
   localparam int DEF_ADC_WIDTH   = 12;
   localparam int DEF_CH_NUM      = 2;
   localparam int DEF_IDX_WIDTH   = 16;
   localparam int DEF_CNT_WIDTH   = 24;

endpackage

// File: rtl/sweep_seq_if.sv
// Per-point result stream from the sweep sequencer toward the SPI readout path.
interface sweep_seq_if #(
   parameter int IDX_WIDTH   = 16,
   parameter int FWORD_WIDTH = 32,
   parameter int AMP_WIDTH   = 24
);
   logic                   res_valid;
   logic                   res_ready;
   logic [IDX_WIDTH-1:0]   res_index;
   logic [FWORD_WIDTH-1:0] res_fword;
   logic [AMP_WIDTH-1:0]   res_amp;

   modport master (
      output res_valid, res_index, res_fword, res_amp,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_index, res_fword, res_amp,
      output res_ready
   );
endinterface

// File: rtl/sweep_minmax.sv
// One ADC channel: running max/min over a measurement window and their difference.
module sweep_minmax #(
   parameter int ADC_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clr,
   input  logic                 smp,
   input  logic [ADC_WIDTH-1:0] din,
   output logic [ADC_WIDTH-1:0] amp
);
   logic [ADC_WIDTH-1:0] max_q, min_q, max_n, min_n;

   // amp already includes the sample being strobed this cycle, so the final
   // sample of a window is reflected in the value captured on the same edge
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      max_n = max_q;
      min_n = min_q;
      if (smp) begin
         if (din > max_q) max_n = din;
         if (din < min_q) min_n = din;
      end
      amp = max_n - min_n;
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
      if (!rstn) begin
         max_q <= '0;
         min_q <= '1;
      end else if (clr) begin
         max_q <= '0;
         min_q <= '1;
      end else begin
         max_q <= max_n;
         min_q <= min_n;
      end
   end
endmodule

// File: rtl/sweep_seq.sv
// Frequency-sweep sequencer: steps the DDS word, settles, measures p-p amplitude per channel.
module sweep_seq import sweep_pkg::*; #(
   parameter int FWORD_WIDTH = DEF_FWORD_WIDTH,
   parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
   parameter int CH_NUM      = DEF_CH_NUM,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        param_wen,
   input  logic [FWORD_WIDTH-1:0]      f_start,
   input  logic [FWORD_WIDTH-1:0]      f_step,
   input  logic [IDX_WIDTH-1:0]        n_points,
   input  logic [CNT_WIDTH-1:0]        settle_cycles,
   input  logic [CNT_WIDTH-1:0]        meas_samples,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        adc_valid,
   input  logic [CH_NUM*ADC_WIDTH-1:0] adc_data,
   output logic [FWORD_WIDTH-1:0]      fword,
   output logic                        fword_upd,
   output logic                        busy,
   output logic                        done,
   sweep_seq_if.master                 res_if
);
   state_t state, state_nxt;

   logic [FWORD_WIDTH-1:0]      f_start_q, f_step_q;
   logic [IDX_WIDTH-1:0]        n_q, index;
   logic [CNT_WIDTH-1:0]        settle_q, meas_q, cnt;
   logic [CNT_WIDTH-1:0]        settle_eff, meas_eff;
   logic [CH_NUM*ADC_WIDTH-1:0] amp_all;
   logic go_start, go_meas, smp, cap, adv, fin;

   // a zero setting still means one cycle / one sample
   assign settle_eff = (settle_q == '0) ? CNT_WIDTH'(1) : settle_q;
   assign meas_eff   = (meas_q == '0) ? CNT_WIDTH'(1) : meas_q;

   assign busy             = (state != ST_IDLE);
   assign res_if.res_valid = (state == ST_OUT);

   always_comb begin
      state_nxt = state;
      go_start  = 1'b0;
      go_meas   = 1'b0;
      smp       = 1'b0;
      cap       = 1'b0;
      adv       = 1'b0;
      fin       = 1'b0;
      case (state)
         ST_IDLE:
            if (start && n_q != '0) begin
               go_start  = 1'b1;
               state_nxt = ST_SETTLE;
            end
         ST_SETTLE:
            if (cnt == settle_eff - 1'b1) begin
               go_meas   = 1'b1;
               state_nxt = ST_MEAS;
            end
         ST_MEAS:
            if (adc_valid) begin
               smp = 1'b1;
               if (cnt == meas_eff - 1'b1) begin
                  cap       = 1'b1;
                  state_nxt = ST_OUT;
               end
            end
         ST_OUT:
            if (res_if.res_ready) begin
               if (index == n_q - 1'b1) begin
                  fin       = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  adv       = 1'b1;
                  state_nxt = ST_SETTLE;
               end
            end
         default: state_nxt = ST_IDLE;
      endcase
      // abort overrides every transition, including a same-cycle handshake
      if (abort) begin
         state_nxt = ST_IDLE;
         go_start  = 1'b0;
         go_meas   = 1'b0;
         smp       = 1'b0;
         cap       = 1'b0;
         adv       = 1'b0;
         fin       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: config shadows and result registers are real control state, so they take reset.
      if (!rstn) begin
         f_start_q        <= '0;
         f_step_q         <= '0;
         n_q              <= '0;
         settle_q         <= '0;
         meas_q           <= '0;
         fword            <= '0;
         fword_upd        <= 1'b0;
         done             <= 1'b0;
         index            <= '0;
         cnt              <= '0;
         res_if.res_index <= '0;
         res_if.res_fword <= '0;
         res_if.res_amp   <= '0;
      end else begin
         fword_upd <= go_start | adv;
         done      <= fin;
         if (state == ST_IDLE && param_wen) begin
            f_start_q <= f_start;
            f_step_q  <= f_step;
            n_q       <= n_points;
            settle_q  <= settle_cycles;
            meas_q    <= meas_samples;
         end
         if (state == ST_SETTLE) cnt <= go_meas ? '0 : cnt + 1'b1;
         if (smp && !cap) cnt <= cnt + 1'b1;
         if (go_start) begin
            fword <= f_start_q;
            index <= '0;
            cnt   <= '0;
         end
         if (adv) begin
            fword <= fword + f_step_q;
            index <= index + 1'b1;
            cnt   <= '0;
         end
         if (cap) begin
            res_if.res_index <= index;
            res_if.res_fword <= fword;
            res_if.res_amp   <= amp_all;
         end
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      sweep_minmax #(.ADC_WIDTH(ADC_WIDTH)) u_minmax (
         .clk  (clk),
         .rstn (rstn),
         .clr  (go_meas),
         .smp  (smp),
         .din  (adc_data[g*ADC_WIDTH +: ADC_WIDTH]),
         .amp  (amp_all[g*ADC_WIDTH +: ADC_WIDTH])
      );
   end
endmodule

// File: tb/tb_sweep_seq.sv
// Bench for sweep_seq: table of sweep configs scored against a timing-level model.
module tb_sweep_seq;
   localparam int FW = 32;
   localparam int AW = 12;
   localparam int CH = 2;
   localparam int IW = 16;
   localparam int CW = 24;

   logic clk = 1'b0;
   logic rstn;
   logic param_wen, start, abort, adc_valid, res_ready;
   logic [FW-1:0] f_start, f_step;
   logic [IW-1:0] n_points;
   logic [CW-1:0] settle_cycles, meas_samples;
   logic [CH*AW-1:0] adc_data;
   logic [FW-1:0] fword;
   logic fword_upd, busy, done;
   logic res_valid;
   logic [IW-1:0] res_index;
   logic [FW-1:0] res_fword;
   logic [CH*AW-1:0] res_amp;

   always #5 clk = ~clk;

   sweep_seq_if #(.IDX_WIDTH(IW), .FWORD_WIDTH(FW), .AMP_WIDTH(CH*AW)) res_if ();
   assign res_if.res_ready = res_ready;
   assign res_valid = res_if.res_valid;
   assign res_index = res_if.res_index;
   assign res_fword = res_if.res_fword;
   assign res_amp   = res_if.res_amp;

   sweep_seq #(
      .FWORD_WIDTH(FW), .ADC_WIDTH(AW), .CH_NUM(CH), .IDX_WIDTH(IW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rstn(rstn), .param_wen(param_wen), .f_start(f_start), .f_step(f_step),
      .n_points(n_points), .settle_cycles(settle_cycles), .meas_samples(meas_samples),
      .start(start), .abort(abort), .adc_valid(adc_valid), .adc_data(adc_data),
      .fword(fword), .fword_upd(fword_upd), .busy(busy), .done(done), .res_if(res_if)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus for ADC and consumer ----------------
   int dmode = 0;   // 0 random, 1 ch0 cycles 100..900 / ch1 2048, 2 ramp
   int rmode = 0;   // 0 always ready, 1 random, 2 hold off >20 cycles per result
   initial begin
      int vcnt, k;
      vcnt = 0;
      k = 0;
      adc_valid = 1'b0;
      adc_data  = '0;
      res_ready = 1'b0;
      forever begin
         step();
         k++;
         case (dmode)
            1: begin
               adc_valid = 1'b1;
               adc_data  = {12'd2048, 12'(100 * (k % 9 + 1))};
            end
            2: begin
               adc_valid = 1'b1;
               adc_data  = {~12'(k), 12'(k)};
            end
            default: begin
               adc_valid = ($urandom % 2) == 1;
               adc_data  = 24'($urandom);
            end
         endcase
         vcnt = res_valid ? vcnt + 1 : 0;
         case (rmode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom % 3) != 0;
            default: res_ready = (vcnt > 20);
         endcase
      end
   end

   // ---------------- reference model ----------------
   // Works from the timing rules: fword_upd at u -> samples counted from u+max(S,1);
   // result the cycle after the last counted sample; next point the cycle after handshake.
   logic [FW-1:0] m_start, m_step;
   int m_n, s_eff, m_eff;
   bit mdl_en = 1'b0;
   int cyc = 0;
   int pt, win_start, nsamp, n_res, n_done;
   bit collecting, fw_known;
   bit e_busy, e_upd, e_done, e_rv;
   logic [FW-1:0] e_fw, e_rfw, last_fw;
   logic [IW-1:0] e_idx;
   logic [CH*AW-1:0] e_amp, last_amp;
   logic [AW-1:0] lo [CH];
   logic [AW-1:0] hi [CH];

   task open_point();
      e_fw       = m_start + 32'(pt) * m_step;
      e_upd      = 1'b1;
      fw_known   = 1'b1;
      win_start  = cyc + 1 + s_eff;
      collecting = 1'b1;
      nsamp      = 0;
      for (int c = 0; c < CH; c++) begin
         lo[c] = '1;
         hi[c] = '0;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (mdl_en) begin
         check("busy", busy, e_busy);
         check("fword_upd", fword_upd, e_upd);
         check("done", done, e_done);
         check("res_valid", res_valid, e_rv);
         if (fw_known) check("fword", fword, e_fw);
         if (e_rv) begin
            check("res_index", res_index, e_idx);
            check("res_fword", res_fword, e_rfw);
            check("res_amp", res_amp, e_amp);
         end
         if (done) n_done++;
         e_upd  = 1'b0;
         e_done = 1'b0;
         if (!e_busy) begin
            if (start && m_n != 0) begin
               e_busy = 1'b1;
               pt = 0;
               open_point();
            end
         end else if (collecting) begin
            if (cyc >= win_start && adc_valid) begin
               for (int c = 0; c < CH; c++) begin
                  if (adc_data[c*AW +: AW] > hi[c]) hi[c] = adc_data[c*AW +: AW];
                  if (adc_data[c*AW +: AW] < lo[c]) lo[c] = adc_data[c*AW +: AW];
               end
               nsamp++;
               if (nsamp == m_eff) begin
                  collecting = 1'b0;
                  e_rv  = 1'b1;
                  e_idx = IW'(pt);
                  e_rfw = e_fw;
                  for (int c = 0; c < CH; c++) e_amp[c*AW +: AW] = hi[c] - lo[c];
               end
            end
         end else if (e_rv && res_ready) begin
            e_rv = 1'b0;
            n_res++;
            last_fw  = res_fword;
            last_amp = res_amp;
            if (pt == m_n - 1) begin
               e_done = 1'b1;
               e_busy = 1'b0;
            end else begin
               pt++;
               open_point();
            end
         end
      end
   end

   // ---------------- test sequencing ----------------
   typedef struct {
      logic [FW-1:0] f_start;
      logic [FW-1:0] f_step;
      int            n;
      int            s;
      int            m;
      int            dmode;
      int            rmode;
      logic [FW-1:0] exp_last_fw;
      bit            chk_amp;
      logic [CH*AW-1:0] exp_amp;
   } vec_t;

   task automatic load_cfg(input vec_t v);
      f_start       = v.f_start;
      f_step        = v.f_step;
      n_points      = IW'(v.n);
      settle_cycles = CW'(v.s);
      meas_samples  = CW'(v.m);
      param_wen     = 1'b1;
      step();
      param_wen     = 1'b0;
   endtask

   // Runs one sweep with the model attached, using the config the model is told about.
   task automatic run_model(input vec_t v);
      m_start = v.f_start;
      m_step  = v.f_step;
      m_n     = v.n;
      s_eff   = (v.s == 0) ? 1 : v.s;
      m_eff   = (v.m == 0) ? 1 : v.m;
      dmode   = v.dmode;
      rmode   = v.rmode;
      e_busy = 0; e_rv = 0; e_upd = 0; e_done = 0;
      fw_known = 0; collecting = 0; n_res = 0; n_done = 0;
      mdl_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 5000 && n_done == 0; c++) step();
      check("sweep_finished", n_done != 0, 1);
      repeat (3) step();
      mdl_en = 1'b0;
      check("result_count", n_res, v.n);
      check("done_count", n_done, 1);
      check("last_res_fword", last_fw, v.exp_last_fw);
      if (v.chk_amp) check("pattern_res_amp", last_amp, v.exp_amp);
   endtask

   vec_t vecs[6];
   vec_t cfg_a;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int ups, c;
      bit any_rv, any_done, any_upd;

      vecs[0] = '{32'd1000, 32'd250, 4, 10, 8, 2, 0, 32'd1750, 1'b0, 24'h0};
      vecs[1] = '{32'd5000, 32'd1, 2, 3, 9, 1, 0, 32'd5001, 1'b1, {12'd0, 12'd800}};
      vecs[2] = '{32'd200, 32'd30, 3, 4, 3, 0, 2, 32'd260, 1'b0, 24'h0};
      vecs[3] = '{32'hFFFF_FF00, 32'h200, 2, 5, 4, 0, 1, 32'h0000_0100, 1'b0, 24'h0};
      vecs[4] = '{32'd7, 32'd9, 3, 0, 0, 0, 0, 32'd25, 1'b0, 24'h0};
      vecs[5] = '{32'd123456, 32'd777, 6, 2, 6, 0, 1, 32'd127341, 1'b0, 24'h0};
      cfg_a   = '{32'd3000, 32'd100, 4, 3, 5, 2, 0, 32'd3300, 1'b0, 24'h0};

      rstn = 1'b0;
      param_wen = 0; start = 0; abort = 0;
      f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0; meas_samples = '0;
      #22;
      check("rst_fword", fword, 0);
      check("rst_fword_upd", fword_upd, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_index", res_index, 0);
      check("rst_res_fword", res_fword, 0);
      check("rst_res_amp", res_amp, 0);
      step();
      rstn = 1'b1;
      step();

      // shadow n_points resets to 0, so a bare start is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("n0_rst_busy", busy, 0);
         check("n0_rst_upd", fword_upd, 0);
         step();
      end
      load_cfg('{32'd55, 32'd1, 0, 5, 5, 0, 0, 32'd0, 1'b0, 24'h0});
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("n0_busy", busy, 0);
         check("n0_upd", fword_upd, 0);
         step();
      end

      // abort during MEAS of point 1, with an ignored param_wen while busy
      load_cfg(cfg_a);
      dmode = 2;
      rmode = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      ups = int'(fword_upd);
      f_start = '0; f_step = 32'd1; n_points = 16'd1; settle_cycles = '0; meas_samples = '0;
      param_wen = 1'b1;
      step();
      param_wen = 1'b0;
      ups += int'(fword_upd);
      c = 0;
      while (ups < 2 && c < 300) begin
         step();
         ups += int'(fword_upd);
         c++;
      end
      check("abort_reached_point1", ups, 2);
      repeat (4) step();
      check("abort_pre_busy", busy, 1);
      check("abort_pre_res_valid", res_valid, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_done", done, 0);
      check("abort_fword_kept", fword, 32'd3100);
      any_rv = 0; any_done = 0; any_upd = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         any_rv   |= res_valid;
         any_done |= done;
         any_upd  |= fword_upd;
      end
      check("post_abort_res_valid", any_rv, 0);
      check("post_abort_done", any_done, 0);
      check("post_abort_fword_upd", any_upd, 0);

      // restart without reloading: shadow must still hold cfg_a
      run_model(cfg_a);

      foreach (vecs[i]) begin
         load_cfg(vecs[i]);
         run_model(vecs[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sweep_seq.md
# sweep_seq

Parametrised frequency-sweep sequencer for the frequency response detector. Steps the DDS frequency word from a start value by a fixed step over N points, waits a programmable settle time at each point, then measures peak-to-peak amplitude on CH_NUM ADC channels. Emits one result per point on a valid/ready stream toward the SPI readout path. It replaces single-shot, fixed two-channel ramp control with configurable point count, channel count, settle time, measurement length, abort and output backpressure.

## Interface
- FWORD_WIDTH, 32, DDS frequency word width
- ADC_WIDTH, 12, ADC sample width (offset binary, unsigned)
- CH_NUM, 2, number of measured ADC channels
- IDX_WIDTH, 16, point index / point count width
- CNT_WIDTH, 24, settle and measurement counter width
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- param_wen  in  1  one-cycle pulse; latches f_start, f_step, n_points, settle_cycles, meas_samples (honoured only in IDLE)
- f_start  in  FWORD_WIDTH  first frequency word
- f_step  in  FWORD_WIDTH  frequency increment per point
- n_points  in  IDX_WIDTH  number of points
- settle_cycles  in  CNT_WIDTH  clk cycles to wait after each frequency change
- meas_samples  in  CNT_WIDTH  adc_valid samples per measurement
- start  in  1  one-cycle pulse, begin sweep
- abort  in  1  level/pulse, terminate sweep
- adc_valid  in  1  sample strobe, already synchronised to clk
- adc_data  in  CH_NUM*ADC_WIDTH  channel k at bits [k*ADC_WIDTH +: ADC_WIDTH]
- fword  out  FWORD_WIDTH  current DDS frequency word
- fword_upd  out  1  one-cycle pulse when fword changes
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after last result accepted
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_index  out  IDX_WIDTH  point index of result
- res_fword  out  FWORD_WIDTH  frequency word of result
- res_amp  out  CH_NUM*ADC_WIDTH  per-channel max − min

## Operation
- States: IDLE, SETTLE, MEAS, OUT.
- IDLE: param_wen copies config into shadow registers. start with shadow n_points ≠ 0 → fword ← f_start, index ← 0, settle counter cleared, fword_upd pulse, → SETTLE. start with n_points = 0 ignored.
- SETTLE: counts clk cycles; after max(settle_cycles,1) cycles → MEAS, per-channel max ← 0, min ← all-ones, sample count cleared.
- MEAS: each adc_valid updates every channel's max/min and increments count; on sample number max(meas_samples,1) → OUT, res_amp ← max − min (unsigned, computed including that final sample), res_index ← index, res_fword ← fword.
- OUT: res_valid held with stable payload until res_ready. On handshake: index = n_points−1 → done pulse, → IDLE; else index+1, fword ← fword + f_step (wraps modulo 2^FWORD_WIDTH), fword_upd pulse, → SETTLE.
- abort has priority over all transitions: any state → IDLE next cycle; res_valid drops, pending result discarded, no done. fword retains last value.
- start, param_wen while busy: ignored. Shadow config never changes mid-sweep.
- adc_valid outside MEAS ignored.
- Reset values: fword 0, fword_upd 0, busy 0, done 0, res_valid 0, res_index 0, res_fword 0, res_amp 0, shadow config 0, state IDLE.

## Timing
- All outputs registered.
- start at cycle T → busy, fword, fword_upd valid at T+1.
- settle_cycles = S: MEAS entered at T+1+max(S,1).
- Final sample at cycle M → res_valid at M+1.
- Handshake at cycle H → next fword_upd at H+1; done at H+1 for last point, busy low at H+1.
- res_valid ∧ res_ready same cycle as abort: abort wins, result counts as not accepted.

## Structure
- Package sweep_pkg: state enum, default width constants.
- Sub-module sweep_minmax (one ADC_WIDTH channel: clear, sample strobe, max/min, amplitude), instantiated CH_NUM times via generate.

## Test plan
- f_start=1000, f_step=250, n_points=4, S=10, meas=8, res_ready=1, ramp data → four results, res_fword 1000/1250/1500/1750, index 0–3, one done.
- CH_NUM=2, ch0 samples {100..900}, ch1 constant 2048 → res_amp ch0=800, ch1=0.
- res_ready low 20 cycles in OUT → res_valid and payload stable, fword unchanged, no fword_upd until handshake.
- f_start=0xFFFF_FF00, f_step=0x200, n_points=2 → second res_fword 0x0000_0100.
- abort during MEAS of point 1 → IDLE next cycle, busy 0, no done, no further res_valid; new start works.
- n_points=0 start → busy stays 0; settle_cycles=0, meas_samples=0 → MEAS after 1 cycle, result after 1 sample.
